// File: rtl/cb_executor_pkg.sv
// Shared types and constants for the CB-prefix executor and its decoder.
package cb_executor_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] REG_B   = 3'd0;
    localparam logic [SEL_W-1:0] REG_C   = 3'd1;
    localparam logic [SEL_W-1:0] REG_D   = 3'd2;
    localparam logic [SEL_W-1:0] REG_E   = 3'd3;
    localparam logic [SEL_W-1:0] REG_H   = 3'd4;
    localparam logic [SEL_W-1:0] REG_L   = 3'd5;
    localparam logic [SEL_W-1:0] REG_HLI = 3'd6;
    localparam logic [SEL_W-1:0] REG_A   = 3'd7;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REG,
        ST_MEM_RD,
        ST_EXEC,
        ST_MEM_WR,
        ST_WB
    } cb_state_t;

    typedef enum logic [1:0] {
        CB_SHIFT,
        CB_BIT,
        CB_RES,
        CB_SET
    } cb_class_t;

    typedef enum logic [4:0] {
        alu_NOP,
        alu_ADD,
        alu_ADC,
        alu_SUB,
        alu_SBC,
        alu_AND,
        alu_XOR,
        alu_OR,
        alu_CP,
        alu_INC,
        alu_DEC,
        alu_RLC,
        alu_RRC,
        alu_RL,
        alu_RR,
        alu_SLA,
        alu_SRA,
        alu_SWAP,
        alu_SRL
    } alu_op_t;

    // One-hot mask for a bit index within a data byte.
    function automatic logic [DATA_W-1:0] bit_mask(input logic [SEL_W-1:0] idx);
        return DATA_W'(1) << idx;
    endfunction

endpackage

// File: rtl/cb_executor_decode.sv
// Combinational decode of a CB opcode byte into class, shift op, bit index and operand.
module cb_decode
    import cb_executor_pkg::*;
(
    input  logic [DATA_W-1:0] cb_opcode,
    output cb_class_t         cls_c,
    output alu_op_t           alu_op_c,
    output logic [SEL_W-1:0]  bit_idx_c,
    output logic [SEL_W-1:0]  reg_idx_c,
    output logic              is_mem_c
);

    always_comb begin
        cls_c     = cb_class_t'(cb_opcode[7:6]);
        bit_idx_c = cb_opcode[5:3];
        reg_idx_c = cb_opcode[2:0];
        is_mem_c  = (cb_opcode[2:0] == REG_HLI);
        alu_op_c  = alu_NOP;
        case (cb_opcode[5:3])
            3'd0:    alu_op_c = alu_RLC;
            3'd1:    alu_op_c = alu_RRC;
            3'd2:    alu_op_c = alu_RL;
            3'd3:    alu_op_c = alu_RR;
            3'd4:    alu_op_c = alu_SLA;
            3'd5:    alu_op_c = alu_SRA;
            3'd6:    alu_op_c = alu_SWAP;
            default: alu_op_c = alu_SRL;
        endcase
    end

endmodule

// File: rtl/cb_executor.sv
// Sequential executor for CB-prefixed rotate/shift/swap, BIT, RES and SET instructions.
module cb_executor
    import cb_executor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [DATA_W-1:0] cb_opcode,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  rf_sel,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] hl,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [FLAG_W-1:0] flags_in,
    output logic              flags_we,
    output logic [FLAG_W-1:0] flags_out,
    output logic [DATA_W-1:0] alu_op_A,
    output logic [DATA_W-1:0] alu_op_B,
    output alu_op_t           alu_op_code,
    output logic [FLAG_W-1:0] alu_curr_flags,
    input  logic [FLAG_W-1:0] alu_next_flags,
    input  logic [DATA_W-1:0] alu_result
);

    cb_class_t         dec_cls_c;
    alu_op_t           dec_op_c;
    logic [SEL_W-1:0]  dec_bit_c;
    logic [SEL_W-1:0]  dec_reg_c;
    logic              dec_mem_c;

    cb_decode u_decode (
        .cb_opcode (cb_opcode),
        .cls_c     (dec_cls_c),
        .alu_op_c  (dec_op_c),
        .bit_idx_c (dec_bit_c),
        .reg_idx_c (dec_reg_c),
        .is_mem_c  (dec_mem_c)
    );

    cb_state_t         state_q, state_d;
    cb_class_t         cls_q, cls_d;
    alu_op_t           alu_sel_q, alu_sel_d;
    logic [SEL_W-1:0]  bit_q, bit_d, reg_q, reg_d;
    logic              is_mem_q, is_mem_d;
    logic [FLAG_W-1:0] flags_q, flags_d, rflags_q, rflags_d;
    logic [ADDR_W-1:0] hl_q, hl_d;
    logic [DATA_W-1:0] operand_q, operand_d, result_q, result_d;

    logic              busy_d, done_d, rf_we_d, mem_req_d, mem_we_d, flags_we_d;
    logic [SEL_W-1:0]  rf_sel_d;
    logic [DATA_W-1:0] rf_wdata_d, mem_wdata_d, alu_op_A_d, alu_op_B_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [FLAG_W-1:0] flags_out_d, alu_curr_flags_d;
    alu_op_t           alu_op_code_d;

    logic [DATA_W-1:0] result_c, wb_res_c, exec_opnd_c;
    logic [FLAG_W-1:0] rflags_c, wb_flags_c;
    logic              go_exec_c, go_wb_c;

    // Result and flags of the instruction in EXEC; shifts come straight from the ALU.
    always_comb begin
        result_c = operand_q;
        rflags_c = flags_q;
        case (cls_q)
            CB_SHIFT: begin
                result_c = alu_result;
                rflags_c = alu_next_flags;
            end
            CB_BIT:   rflags_c = {~operand_q[bit_q], 1'b0, 1'b1, flags_q[FLAG_C]};
            CB_RES:   result_c = operand_q & ~bit_mask(bit_q);
            CB_SET:   result_c = operand_q | bit_mask(bit_q);
        endcase
    end

    // WB is entered from EXEC (live result) or from MEM_WR (captured result).
    assign wb_res_c   = (state_q == ST_EXEC) ? result_c : result_q;
    assign wb_flags_c = (state_q == ST_EXEC) ? rflags_c : rflags_q;

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d          = state_q;
        cls_d            = cls_q;
        alu_sel_d        = alu_sel_q;
        bit_d            = bit_q;
        reg_d            = reg_q;
        is_mem_d         = is_mem_q;
        flags_d          = flags_q;
        hl_d             = hl_q;
        operand_d        = operand_q;
        result_d         = result_q;
        rflags_d         = rflags_q;
        busy_d           = busy;
        done_d           = 1'b0;
        rf_we_d          = 1'b0;
        rf_sel_d         = rf_sel;
        rf_wdata_d       = rf_wdata;
        mem_req_d        = 1'b0;
        mem_we_d         = mem_we;
        mem_addr_d       = mem_addr;
        mem_wdata_d      = mem_wdata;
        flags_we_d       = 1'b0;
        flags_out_d      = flags_out;
        alu_op_A_d       = alu_op_A;
        alu_op_B_d       = alu_op_B;
        alu_op_code_d    = alu_NOP;
        alu_curr_flags_d = alu_curr_flags;
        go_exec_c        = 1'b0;
        go_wb_c          = 1'b0;
        exec_opnd_c      = operand_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cls_d     = dec_cls_c;
                    alu_sel_d = dec_op_c;
                    bit_d     = dec_bit_c;
                    reg_d     = dec_reg_c;
                    is_mem_d  = dec_mem_c;
                    flags_d   = flags_in;
                    hl_d      = hl;
                    busy_d    = 1'b1;
                    if (dec_mem_c) begin
                        state_d    = ST_MEM_RD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = hl;
                    end else begin
                        state_d  = ST_RD_REG;
                        rf_sel_d = dec_reg_c;
                    end
                end
            end
            ST_RD_REG: begin
                operand_d   = rf_rdata;
                exec_opnd_c = rf_rdata;
                go_exec_c   = 1'b1;
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    operand_d   = mem_rdata;
                    exec_opnd_c = mem_rdata;
                    go_exec_c   = 1'b1;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = hl_q;
                end
            end
            ST_EXEC: begin
                result_d = result_c;
                rflags_d = rflags_c;
                if (is_mem_q && (cls_q != CB_BIT)) begin
                    state_d     = ST_MEM_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = hl_q;
                    mem_wdata_d = result_c;
                end else begin
                    go_wb_c = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    go_wb_c = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_exec_c) begin
            state_d          = ST_EXEC;
            alu_op_A_d       = '0;
            alu_op_B_d       = exec_opnd_c;
            alu_curr_flags_d = flags_q;
            if (cls_q == CB_SHIFT) alu_op_code_d = alu_sel_q;
        end

        if (go_wb_c) begin
            state_d     = ST_WB;
            done_d      = 1'b1;
            flags_we_d  = (cls_q == CB_SHIFT) || (cls_q == CB_BIT);
            flags_out_d = wb_flags_c;
            if (!is_mem_q && (cls_q != CB_BIT)) begin
                rf_we_d    = 1'b1;
                rf_sel_d   = reg_q;
                rf_wdata_d = wb_res_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= ST_IDLE;
            cls_q          <= CB_SHIFT;
            alu_sel_q      <= alu_NOP;
            bit_q          <= '0;
            reg_q          <= '0;
            is_mem_q       <= 1'b0;
            flags_q        <= '0;
            hl_q           <= '0;
            operand_q      <= '0;
            result_q       <= '0;
            rflags_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rf_we          <= 1'b0;
            rf_sel         <= '0;
            rf_wdata       <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            flags_we       <= 1'b0;
            flags_out      <= '0;
            alu_op_A       <= '0;
            alu_op_B       <= '0;
            alu_op_code    <= alu_NOP;
            alu_curr_flags <= '0;
        end else begin
            state_q        <= state_d;
            cls_q          <= cls_d;
            alu_sel_q      <= alu_sel_d;
            bit_q          <= bit_d;
            reg_q          <= reg_d;
            is_mem_q       <= is_mem_d;
            flags_q        <= flags_d;
            hl_q           <= hl_d;
            operand_q      <= operand_d;
            result_q       <= result_d;
            rflags_q       <= rflags_d;
            busy           <= busy_d;
            done           <= done_d;
            rf_we          <= rf_we_d;
            rf_sel         <= rf_sel_d;
            rf_wdata       <= rf_wdata_d;
            mem_req        <= mem_req_d;
            mem_we         <= mem_we_d;
            mem_addr       <= mem_addr_d;
            mem_wdata      <= mem_wdata_d;
            flags_we       <= flags_we_d;
            flags_out      <= flags_out_d;
            alu_op_A       <= alu_op_A_d;
            alu_op_B       <= alu_op_B_d;
            alu_op_code    <= alu_op_code_d;
            alu_curr_flags <= alu_curr_flags_d;
        end
    end

endmodule

// File: tb/tb_cb_executor.sv
// Self-checking bench for cb_executor: vector table with a scoreboard plus corner-case sequences.
module tb_cb_executor;
    import cb_executor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [7:0]  cb_opcode;
    logic        busy, done, rf_we, mem_req, mem_we, mem_ack, flags_we;
    logic [2:0]  rf_sel;
    logic [7:0]  rf_rdata, rf_wdata, mem_wdata, mem_rdata, alu_op_A, alu_op_B, alu_result;
    logic [15:0] hl, mem_addr;
    logic [3:0]  flags_in, flags_out, alu_curr_flags, alu_next_flags;
    alu_op_t     alu_op_code;

    logic [7:0]  regs [8];
    logic [7:0]  mem_val = 8'h00;
    int          rd_waits = 0;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    logic        wr_block = 1'b0;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0;
    logic [7:0]  wr_data = 8'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cb_executor dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .start          (start),
        .cb_opcode      (cb_opcode),
        .busy           (busy),
        .done           (done),
        .rf_sel         (rf_sel),
        .rf_rdata       (rf_rdata),
        .rf_we          (rf_we),
        .rf_wdata       (rf_wdata),
        .hl             (hl),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .flags_in       (flags_in),
        .flags_we       (flags_we),
        .flags_out      (flags_out),
        .alu_op_A       (alu_op_A),
        .alu_op_B       (alu_op_B),
        .alu_op_code    (alu_op_code),
        .alu_curr_flags (alu_curr_flags),
        .alu_next_flags (alu_next_flags),
        .alu_result     (alu_result)
    );

    assign rf_rdata  = regs[rf_sel];
    assign mem_rdata = mem_val;

    // Reference shift ALU: Z from result, N=H=0, C = bit shifted out.
    logic       alu_c, alu_shift;
    logic [7:0] b;
    always_comb begin
        b              = alu_op_B;
        alu_result     = 8'h00;
        alu_c          = 1'b0;
        alu_shift      = 1'b1;
        alu_next_flags = alu_curr_flags;
        case (alu_op_code)
            alu_RLC:  begin alu_result = {b[6:0], b[7]};              alu_c = b[7]; end
            alu_RRC:  begin alu_result = {b[0], b[7:1]};              alu_c = b[0]; end
            alu_RL:   begin alu_result = {b[6:0], alu_curr_flags[0]}; alu_c = b[7]; end
            alu_RR:   begin alu_result = {alu_curr_flags[0], b[7:1]}; alu_c = b[0]; end
            alu_SLA:  begin alu_result = {b[6:0], 1'b0};              alu_c = b[7]; end
            alu_SRA:  begin alu_result = {b[7], b[7:1]};              alu_c = b[0]; end
            alu_SWAP: begin alu_result = {b[3:0], b[7:4]};            alu_c = 1'b0; end
            alu_SRL:  begin alu_result = {1'b0, b[7:1]};              alu_c = b[0]; end
            default:  alu_shift = 1'b0;
        endcase
        if (alu_shift) alu_next_flags = {alu_result == 8'h00, 1'b0, 1'b0, alu_c};
    end

    // Memory responder: reads ack after rd_waits wait cycles, writes ack at once unless blocked.
    always_comb begin
        mem_ack = stray_ack || (mem_req && (mem_we ? !wr_block : (wait_cnt >= rd_waits)));
    end

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
        if (mem_req && mem_we && mem_ack) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  opnd;
        logic [3:0]  fin;
        logic [15:0] hl;
        int          waits;
        logic [7:0]  res;
        logic [3:0]  flg;
        logic        fwe;
        logic        rfwe;
        logic        memwr;
        int          lat;
    } vec_t;

    vec_t vecs [15];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_done",      32'(done), 32'h0);
        check("rst_rf_we",     32'(rf_we), 32'h0);
        check("rst_rf_sel",    32'(rf_sel), 32'h0);
        check("rst_rf_wdata",  32'(rf_wdata), 32'h0);
        check("rst_mem_req",   32'(mem_req), 32'h0);
        check("rst_mem_we",    32'(mem_we), 32'h0);
        check("rst_mem_addr",  32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_flags_we",  32'(flags_we), 32'h0);
        check("rst_flags_out", 32'(flags_out), 32'h0);
        check("rst_alu_a",     32'(alu_op_A), 32'h0);
        check("rst_alu_b",     32'(alu_op_B), 32'h0);
        check("rst_alu_op",    32'(alu_op_code == alu_NOP), 32'h1);
        check("rst_alu_flags", 32'(alu_curr_flags), 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   lat;
        int   alu_cycles;
        int   wr_before;
        logic got;
        for (int r = 0; r < 8; r++) regs[r] = 8'h5A;
        regs[v.op[2:0]] = v.opnd;
        mem_val   = v.opnd;
        rd_waits  = v.waits;
        hl        = v.hl;
        flags_in  = v.fin;
        wr_before = wr_cnt;
        sb_q.push_back(v);
        cb_opcode = v.op;
        start     = 1'b1;
        lat = 0; alu_cycles = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (alu_op_code != alu_NOP) alu_cycles++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'h0, 32'h1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check("latency",    32'(lat), 32'(e.lat));
        check("busy_done",  32'(busy), 32'h1);
        check("rf_we",      32'(rf_we), 32'(e.rfwe));
        if (e.rfwe) begin
            check("rf_sel",   32'(rf_sel), 32'(e.op[2:0]));
            check("rf_wdata", 32'(rf_wdata), 32'(e.res));
        end
        check("flags_we",   32'(flags_we), 32'(e.fwe));
        if (e.fwe) check("flags_out", 32'(flags_out), 32'(e.flg));
        check("mem_writes", 32'(wr_cnt - wr_before), 32'(e.memwr));
        if (e.memwr) begin
            check("wr_addr", 32'(wr_addr), 32'(e.hl));
            check("wr_data", 32'(wr_data), 32'(e.res));
        end
        check("alu_cycles", 32'(alu_cycles), (e.op[7:6] == 2'b00) ? 32'h1 : 32'h0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'h0);
        check("busy_after", 32'(busy), 32'h0);
        check("strobes_off", 32'({rf_we, flags_we}), 32'h0);
    endtask

    initial begin
        // op, opnd, fin, hl, waits, res, flg, fwe, rfwe, memwr, lat
        vecs[0]  = '{8'h86, 8'hFF, 4'h0, 16'hC000, 2, 8'hFE, 4'h0, 1'b0, 1'b0, 1'b1, 6};
        vecs[1]  = '{8'h00, 8'h85, 4'h0, 16'h0000, 0, 8'h0B, 4'h1, 1'b1, 1'b1, 1'b0, 3};
        vecs[2]  = '{8'h7C, 8'h7F, 4'h1, 16'h0000, 0, 8'h7F, 4'hB, 1'b1, 1'b0, 1'b0, 3};
        vecs[3]  = '{8'h36, 8'h00, 4'h0, 16'hC100, 0, 8'h00, 4'h8, 1'b1, 1'b0, 1'b1, 4};
        vecs[4]  = '{8'h11, 8'h80, 4'h1, 16'h0000, 0, 8'h01, 4'h1, 1'b1, 1'b1, 1'b0, 3};
        vecs[5]  = '{8'h1A, 8'h01, 4'h0, 16'h0000, 0, 8'h00, 4'h9, 1'b1, 1'b1, 1'b0, 3};
        vecs[6]  = '{8'h2B, 8'h81, 4'h0, 16'h0000, 0, 8'hC0, 4'h1, 1'b1, 1'b1, 1'b0, 3};
        vecs[7]  = '{8'h3F, 8'h01, 4'h0, 16'h0000, 0, 8'h00, 4'h9, 1'b1, 1'b1, 1'b0, 3};
        vecs[8]  = '{8'h25, 8'h40, 4'hF, 16'h0000, 0, 8'h80, 4'h0, 1'b1, 1'b1, 1'b0, 3};
        vecs[9]  = '{8'h0C, 8'h01, 4'h0, 16'h0000, 0, 8'h80, 4'h1, 1'b1, 1'b1, 1'b0, 3};
        vecs[10] = '{8'h46, 8'h01, 4'h0, 16'hC200, 1, 8'h01, 4'h2, 1'b1, 1'b0, 1'b0, 4};
        vecs[11] = '{8'h76, 8'h00, 4'h4, 16'hC300, 0, 8'h00, 4'hA, 1'b1, 1'b0, 1'b0, 3};
        vecs[12] = '{8'hC7, 8'hFE, 4'h0, 16'h0000, 0, 8'hFF, 4'h0, 1'b0, 1'b1, 1'b0, 3};
        vecs[13] = '{8'hFE, 8'h00, 4'h0, 16'hC400, 1, 8'h80, 4'h0, 1'b0, 1'b0, 1'b1, 5};
        vecs[14] = '{8'h98, 8'hFF, 4'h0, 16'h0000, 0, 8'hF7, 4'h0, 1'b0, 1'b1, 1'b0, 3};

        for (int r = 0; r < 8; r++) regs[r] = 8'h00;
        rst_b = 1'b0; start = 1'b0; cb_opcode = 8'h00; hl = 16'h0; flags_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // SET 7,A with start held through busy and WB, and stray acks throughout.
        begin
            int dones;
            dones = 0;
            for (int r = 0; r < 8; r++) regs[r] = 8'h00;
            flags_in  = 4'h0;
            stray_ack = 1'b1;
            cb_opcode = 8'hFF;
            start     = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk); #1;
                if (c < 4) begin
                    cb_opcode = 8'h00;
                    start     = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (done) begin
                    dones++;
                    check("set7a_cycle",  32'(c), 32'd3);
                    check("set7a_wdata",  32'(rf_wdata), 32'h80);
                    check("set7a_sel",    32'(rf_sel), 32'd7);
                    check("set7a_rf_we",  32'(rf_we), 32'h1);
                    check("set7a_fl_we",  32'(flags_we), 32'h0);
                end
            end
            check("set7a_one_done", 32'(dones), 32'd1);
            check("wb_start_ignored", 32'(busy), 32'h0);
            stray_ack = 1'b0;
            @(posedge clk); #1;
            check("idle_after_seq", 32'({busy, done}), 32'h0);
        end

        // Reset while a write in MEM_WR is outstanding.
        begin
            int   wr_before;
            int   n;
            logic seen;
            wr_before = wr_cnt;
            wr_block  = 1'b1;
            rd_waits  = 0;
            mem_val   = 8'h12;
            hl        = 16'hD000;
            cb_opcode = 8'hC6;
            start     = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            seen  = 1'b0;
            n     = 0;
            while (!seen && n < 20) begin
                if (mem_req && mem_we) seen = 1'b1;
                else begin
                    @(posedge clk); #1;
                    n++;
                end
            end
            check("reach_mem_wr", 32'(seen), 32'h1);
            @(posedge clk); #1;
            check("mem_wr_held", 32'({mem_req, mem_we}), 32'h3);
            rst_b = 1'b0;
            @(posedge clk); #1;
            check("rst_drop_req", 32'(mem_req), 32'h0);
            check("rst_no_write", 32'(wr_cnt - wr_before), 32'h0);
            check_reset_values();
            rst_b    = 1'b1;
            wr_block = 1'b0;
            @(posedge clk); #1;
            run_vec(vecs[1]);
            run_vec(vecs[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
